// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line rates and
// the bit-timing derivations used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // Clock cycles per serial bit, truncated (10416 at 100 MHz / 9600 baud).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Offset from the start-bit edge to its middle.
    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to the
// idle-high level so a reset never looks like a start bit.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The start bit is re-checked at its midpoint, after which
// every bit is sampled one full bit period later, i.e. mid-bit. The FSM
// leaves at mid-stop-bit so a directly following start edge is not missed.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rx_s
// START | timing half a bit to confirm the start bit (glitch filter)
// DATA  | sampling 8 data bits, LSB first, at mid-bit
// STOP  | sampling the stop bit; high -> byte out, low -> frame error
// BREAK | line held low after a frame error, waiting for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    uart_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt, ferr_nxt;
    logic             rx_s;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    assign o_busy = (state != IDLE);

    // State, timing and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= idx_nxt;
            shreg       <= sh_nxt;
            o_data      <= data_nxt;
            o_valid     <= valid_nxt;
            o_frame_err <= ferr_nxt;
        end
    end

    // Next-state logic: bit timing, sampling and output pulses.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        data_nxt  = o_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_nxt         = '0;
                    sh_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
